// File: rtl/instr_pkg.sv
// Shared constants and types for the instruction sequencer: opcodes, FSM states,
// instruction classes and register-file write-data select encodings.
package instr_pkg;

  localparam logic [5:0] OP_LDI       = 6'd0;
  localparam logic [5:0] OP_MOV       = 6'd1;
  localparam logic [5:0] OP_LD        = 6'd2;
  localparam logic [5:0] OP_ST        = 6'd3;
  localparam logic [5:0] OP_ALU_FIRST = 6'd4;
  localparam logic [5:0] OP_ALU_LAST  = 6'd17;
  localparam logic [5:0] OP_HALT      = 6'd63;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB1,
    S_WB2,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_LDI,
    C_MOV,
    C_LD,
    C_ST,
    C_ALU,
    C_HALT,
    C_ILLEGAL
  } iclass_t;

  localparam logic [2:0] WSEL_IMM    = 3'd0;
  localparam logic [2:0] WSEL_RS2    = 3'd1;
  localparam logic [2:0] WSEL_MEM    = 3'd2;
  localparam logic [2:0] WSEL_ALU_LO = 3'd3;
  localparam logic [2:0] WSEL_ALU_HI = 3'd4;

  function automatic iclass_t classify(input logic [5:0] op);
    if (op == OP_LDI)                              return C_LDI;
    else if (op == OP_MOV)                         return C_MOV;
    else if (op == OP_LD)                          return C_LD;
    else if (op == OP_ST)                          return C_ST;
    else if (op >= OP_ALU_FIRST && op <= OP_ALU_LAST) return C_ALU;
    else if (op == OP_HALT)                        return C_HALT;
    else                                           return C_ILLEGAL;
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational field extraction from the instruction register: class,
// register addresses, immediate, data address and ALU operation.
module instr_field_decode
  import instr_pkg::*;
#(
  parameter int unsigned DA_W = 8
) (
  input  logic [31:0]     code,
  output iclass_t         cls,
  output logic [4:0]      rsrc1,
  output logic [4:0]      rsrc2,
  output logic [4:0]      rdst1,
  output logic [4:0]      rdst2,
  output logic [15:0]     imm,
  output logic [DA_W-1:0] dmem_addr,
  output logic [3:0]      alu_op
);

  logic [5:0] opcode;

  always_comb begin
    opcode = code[31:26];
    cls    = classify(opcode);
    rsrc1  = code[4:0];
    // MOV reads its source through port 2 so the RS2 write path can be reused
    rsrc2  = (opcode == OP_MOV) ? code[4:0] : code[9:5];
    rdst1  = code[20:16];
    rdst2  = code[25:21];
    imm    = code[15:0];

    dmem_addr = '0;
    if (cls == C_LD)      dmem_addr = DA_W'(code[7:0]);
    else if (cls == C_ST) dmem_addr = DA_W'(code[25:18]);

    alu_op = '0;
    if (cls == C_ALU) alu_op = 4'(opcode - OP_ALU_FIRST);
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control unit: fetches instruction words, owns the PC and steps
// the register file, ALU and data memory through a fixed state machine.
module instr_sequencer
  import instr_pkg::*;
#(
  parameter int unsigned PC_W = 8,
  parameter int unsigned DA_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [4:0]      rf_raddr1,
  output logic [4:0]      rf_raddr2,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [2:0]      rf_wsel,
  output logic [15:0]     imm,
  output logic [3:0]      alu_op,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [DA_W-1:0] dmem_addr,
  input  logic            dmem_ack,
  output logic            halted,
  output logic            illegal
);

  state_t          state_q, state_d;
  logic [31:0]     ir_q, ir_d;
  logic [PC_W-1:0] pc_q, pc_d;

  iclass_t    cls;
  logic [4:0] rdst1, rdst2;

  instr_field_decode #(.DA_W(DA_W)) u_decode (
    .code      (ir_q),
    .cls       (cls),
    .rsrc1     (rf_raddr1),
    .rsrc2     (rf_raddr2),
    .rdst1     (rdst1),
    .rdst2     (rdst2),
    .imm       (imm),
    .dmem_addr (dmem_addr),
    .alu_op    (alu_op)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (cls)
          C_LDI, C_MOV: state_d = S_WB1;
          C_LD, C_ST:   state_d = S_MEM;
          C_ALU:        state_d = S_EXEC;
          C_HALT:       state_d = S_HALT;
          default:      state_d = S_FETCH;
        endcase
      end
      S_EXEC: state_d = S_WB1;
      S_MEM: begin
        if (dmem_ack) state_d = (cls == C_LD) ? S_WB1 : S_FETCH;
      end
      S_WB1:  state_d = (cls == C_ALU) ? S_WB2 : S_FETCH;
      S_WB2:  state_d = S_FETCH;
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Every strobe is decoded from the registered state so that an asynchronous
  // reset drives all outputs to their idle values immediately.
  always_comb begin
    imem_req  = (state_q == S_FETCH);
    imem_addr = pc_q;
    dmem_req  = (state_q == S_MEM);
    dmem_we   = (state_q == S_MEM) && (cls == C_ST);
    rf_we     = (state_q == S_WB1) || (state_q == S_WB2);
    rf_waddr  = (state_q == S_WB2) ? rdst1 : rdst2;
    halted    = (state_q == S_HALT);
    illegal   = (state_q == S_DECODE) && (cls == C_ILLEGAL);

    rf_wsel = WSEL_IMM;
    if (state_q == S_WB2) begin
      rf_wsel = WSEL_ALU_HI;
    end else begin
      case (cls)
        C_MOV:   rf_wsel = WSEL_RS2;
        C_LD:    rf_wsel = WSEL_MEM;
        C_ALU:   rf_wsel = WSEL_ALU_LO;
        default: rf_wsel = WSEL_IMM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer: memories are driven by hand
// cycle by cycle and every output is compared against hand-derived values.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [2:0]  rf_wsel;
  logic [15:0] imm;
  logic [3:0]  alu_op;
  logic        dmem_req, dmem_we;
  logic [7:0]  dmem_addr;
  logic        dmem_ack;
  logic        halted, illegal;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  instr_sequencer #(.PC_W(8), .DA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .rf_raddr1  (rf_raddr1),
    .rf_raddr2  (rf_raddr2),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wsel    (rf_wsel),
    .imm        (imm),
    .alu_op     (alu_op),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_ack   (dmem_ack),
    .halted     (halted),
    .illegal    (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    dmem_ack   = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_imem_req",  32'(imem_req),  32'd1);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_dmem_req",  32'(dmem_req),  32'd0);
    chk("rst_dmem_we",   32'(dmem_we),   32'd0);
    chk("rst_rf_we",     32'(rf_we),     32'd0);
    chk("rst_illegal",   32'(illegal),   32'd0);
    chk("rst_halted",    32'(halted),    32'd0);
    chk("rst_buses",     {4'(alu_op), 8'(dmem_addr), 16'(imm), 3'(rf_wsel), 1'b0}, 32'd0);
    chk("rst_raddrs",    32'({rf_raddr1, rf_raddr2, rf_waddr}), 32'd0);
    rst_n = 1'b1;

    // LDI r0, 0x1234 with zero-wait fetch
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_1234;
    chk("ldi_fetch_req",  32'(imem_req),  32'd1);
    chk("ldi_fetch_addr", 32'(imem_addr), 32'd0);
    step();
    imem_ack = 1'b0;
    chk("ldi_dec_req",  32'(imem_req), 32'd0);
    chk("ldi_dec_we",   32'(rf_we),    32'd0);
    step();
    chk("ldi_wb1_we",    32'(rf_we),    32'd1);
    chk("ldi_wb1_waddr", 32'(rf_waddr), 32'd0);
    chk("ldi_wb1_wsel",  32'(rf_wsel),  32'd0);
    chk("ldi_wb1_imm",   32'(imm),      32'h1234);
    step();
    chk("ldi_next_req",  32'(imem_req),  32'd1);
    chk("ldi_next_pc",   32'(imem_addr), 32'd1);
    chk("ldi_next_we",   32'(rf_we),     32'd0);

    // LD r2, [0x55] with three data wait cycles
    imem_ack   = 1'b1;
    imem_rdata = 32'h0840_0055;
    step();
    imem_ack = 1'b0;
    chk("ld_dec_dreq", 32'(dmem_req), 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("ld_mem_dreq",  32'(dmem_req),  32'd1);
      chk("ld_mem_daddr", 32'(dmem_addr), 32'h55);
      chk("ld_mem_dwe",   32'(dmem_we),   32'd0);
      chk("ld_mem_ireq",  32'(imem_req),  32'd0);
      chk("ld_mem_rfwe",  32'(rf_we),     32'd0);
      if (i == 3) dmem_ack = 1'b1;
      step();
    end
    dmem_ack = 1'b0;
    chk("ld_wb1_dreq",  32'(dmem_req), 32'd0);
    chk("ld_wb1_we",    32'(rf_we),    32'd1);
    chk("ld_wb1_waddr", 32'(rf_waddr), 32'd2);
    chk("ld_wb1_wsel",  32'(rf_wsel),  32'd2);
    step();
    chk("ld_next_pc", 32'(imem_addr), 32'd2);
    chk("ld_next_req", 32'(imem_req), 32'd1);

    // ALU op 5: Rdst2=3, Rdst1=4, Rsrc2=1, Rsrc1=2
    imem_ack   = 1'b1;
    imem_rdata = 32'h1464_0022;
    step();
    imem_ack = 1'b0;
    chk("alu_dec_raddr1", 32'(rf_raddr1), 32'd2);
    chk("alu_dec_raddr2", 32'(rf_raddr2), 32'd1);
    chk("alu_dec_op",     32'(alu_op),    32'd1);
    chk("alu_dec_we",     32'(rf_we),     32'd0);
    step();
    chk("alu_exec_we", 32'(rf_we),  32'd0);
    chk("alu_exec_op", 32'(alu_op), 32'd1);
    step();
    chk("alu_wb1_we",    32'(rf_we),    32'd1);
    chk("alu_wb1_waddr", 32'(rf_waddr), 32'd3);
    chk("alu_wb1_wsel",  32'(rf_wsel),  32'd3);
    chk("alu_wb1_op",    32'(alu_op),   32'd1);
    step();
    chk("alu_wb2_we",    32'(rf_we),    32'd1);
    chk("alu_wb2_waddr", 32'(rf_waddr), 32'd4);
    chk("alu_wb2_wsel",  32'(rf_wsel),  32'd4);
    chk("alu_wb2_op",    32'(alu_op),   32'd1);
    step();
    chk("alu_next_req", 32'(imem_req),  32'd1);
    chk("alu_next_pc",  32'(imem_addr), 32'd3);
    chk("alu_next_we",  32'(rf_we),     32'd0);

    // Illegal opcode 20, then HALT
    imem_ack   = 1'b1;
    imem_rdata = 32'h5000_0000;
    step();
    imem_ack = 1'b0;
    chk("ill_pulse", 32'(illegal), 32'd1);
    step();
    chk("ill_clear",    32'(illegal),   32'd0);
    chk("ill_next_req", 32'(imem_req),  32'd1);
    chk("ill_next_pc",  32'(imem_addr), 32'd4);
    imem_ack   = 1'b1;
    imem_rdata = 32'hFC00_0000;
    step();
    imem_ack = 1'b0;
    chk("halt_dec_ill", 32'(illegal), 32'd0);
    chk("halt_dec_hlt", 32'(halted),  32'd0);
    step();
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("halt_halted", 32'(halted),   32'd1);
      chk("halt_ireq",   32'(imem_req), 32'd0);
      chk("halt_dreq",   32'(dmem_req), 32'd0);
      chk("halt_pc",     32'(imem_addr), 32'd5);
      step();
    end
    imem_ack = 1'b0;

    // Asynchronous reset out of HALT, mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_halted", 32'(halted),    32'd0);
    chk("arst_ireq",   32'(imem_req),  32'd1);
    chk("arst_pc",     32'(imem_addr), 32'd0);
    step();
    rst_n = 1'b1;

    // Walk the PC to 0xFF with illegal opcodes, then check the wrap
    for (int i = 0; i < 255; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'h5000_0000;
      step();
      imem_ack = 1'b0;
      step();
    end
    chk("wrap_pc_ff",  32'(imem_addr), 32'hFF);
    chk("wrap_req",    32'(imem_req),  32'd1);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_00AA;
    step();
    imem_ack = 1'b0;
    step();
    chk("wrap_wb1_we",  32'(rf_we), 32'd1);
    chk("wrap_wb1_imm", 32'(imm),   32'hAA);
    step();
    chk("wrap_pc_00", 32'(imem_addr), 32'h00);
    chk("wrap_req2",  32'(imem_req),  32'd1);

    // Reset during a pending store; the late data ack must be ignored
    imem_ack   = 1'b1;
    imem_rdata = 32'h0CF0_0000;
    step();
    imem_ack = 1'b0;
    step();
    chk("st_mem_dreq",  32'(dmem_req),  32'd1);
    chk("st_mem_dwe",   32'(dmem_we),   32'd1);
    chk("st_mem_daddr", 32'(dmem_addr), 32'h3C);
    chk("st_mem_ireq",  32'(imem_req),  32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("strst_dreq",  32'(dmem_req),  32'd0);
    chk("strst_dwe",   32'(dmem_we),   32'd0);
    chk("strst_daddr", 32'(dmem_addr), 32'd0);
    chk("strst_ireq",  32'(imem_req),  32'd1);
    chk("strst_pc",    32'(imem_addr), 32'd0);
    dmem_ack = 1'b1;
    step();
    rst_n = 1'b1;
    chk("strst_ack_ireq", 32'(imem_req), 32'd1);
    chk("strst_ack_dreq", 32'(dmem_req), 32'd0);
    step();
    chk("strst_idle_ireq", 32'(imem_req),  32'd1);
    chk("strst_idle_pc",   32'(imem_addr), 32'd0);
    chk("strst_idle_we",   32'(rf_we),     32'd0);
    dmem_ack = 1'b0;

    // Fetch restarts at PC 0: LDI r1, 7
    imem_ack   = 1'b1;
    imem_rdata = 32'h0020_0007;
    step();
    imem_ack = 1'b0;
    step();
    chk("restart_we",    32'(rf_we),    32'd1);
    chk("restart_waddr", 32'(rf_waddr), 32'd1);
    chk("restart_wsel",  32'(rf_wsel),  32'd0);
    chk("restart_imm",   32'(imm),      32'd7);
    step();
    chk("restart_pc", 32'(imem_addr), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
